// File: rtl/seven_segment_scan_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_decoder
//
// Purpose
//   Watches the multiplexed drive of an eight-digit seven-segment display
//   (a stopwatch showing MM:SS.CC on digits 5..0) and recovers the displayed
//   time as binary fields. Each digit is accepted only after its an/seg
//   pair has stayed unchanged for SETTLE_CYCLES clocks. Once all six used
//   digits have been captured, the frame is range-checked and published.
//
// Parameters
//   SETTLE_CYCLES  consecutive stable cycles of an/seg before capture (2..255)
//   CLK_HZ         clk frequency, informational only
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active high
//   seg[6:0]      in   segment bus, active low, {g,f,e,d,c,b,a}
//   an[7:0]       in   digit enables, active low, an[0] = rightmost digit
//   minutes[5:0]  out  last accepted minutes, 0..59
//   seconds[5:0]  out  last accepted seconds, 0..59
//   centiseconds  out  last accepted centiseconds, 0..99 (7 bits)
//   frame_valid   out  one-cycle pulse when the time outputs update
//   decode_err    out  one-cycle pulse on illegal pattern, illegal an, or
//                      out-of-range frame
//
// Optional feature
//   SEG_DECODER_CONFIRM_EN : when defined, a completed in-range frame is only
//   published if it equals the previous completed in-range frame; otherwise
//   it just becomes the new comparison reference.
// -----------------------------------------------------------------------------
module seven_segment_scan_decoder #(
   parameter int SETTLE_CYCLES = 16,
   parameter int CLK_HZ        = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg,
   input  logic [7:0] an,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [6:0] centiseconds,
   output logic       frame_valid,
   output logic       decode_err
);

   localparam bit PARAMS_OK = (SETTLE_CYCLES >= 2) && (SETTLE_CYCLES <= 255) && (CLK_HZ > 0);

   generate
      if (!PARAMS_OK) begin : g_param_check
         $error("seven_segment_scan_decoder: SETTLE_CYCLES must be 2..255 and CLK_HZ positive");
      end
   endgenerate

   // The counter is cleared on the first cycle of a new an/seg value, so the
   // value has been stable for SETTLE_CYCLES cycles when the counter is about
   // to step from SETTLE_CYCLES-2 to SETTLE_CYCLES-1.
   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_t;

   // Returns {legal, digit} for an active-low {g..a} pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h40:   r = {1'b1, 4'd0};
         7'h79:   r = {1'b1, 4'd1};
         7'h24:   r = {1'b1, 4'd2};
         7'h30:   r = {1'b1, 4'd3};
         7'h19:   r = {1'b1, 4'd4};
         7'h12:   r = {1'b1, 4'd5};
         7'h02:   r = {1'b1, 4'd6};
         7'h78:   r = {1'b1, 4'd7};
         7'h00:   r = {1'b1, 4'd8};
         7'h10:   r = {1'b1, 4'd9};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

   // Minutes/seconds only reach the outputs when tens <= 5, so 6 bits hold them.
   function automatic logic [5:0] join_bcd6(input logic [3:0] tens, input logic [3:0] ones);
      return ({2'b00, tens} * 6'd10) + {2'b00, ones};
   endfunction

   function automatic logic [6:0] join_bcd7(input logic [3:0] tens, input logic [3:0] ones);
      return ({3'b000, tens} * 7'd10) + {3'b000, ones};
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       an_prev_q, an_prev_d;
   logic [6:0]       seg_prev_q, seg_prev_d;
   logic [5:0]       mask_q, mask_d;
   logic [5:0][3:0]  digit_q, digit_d;
   logic [5:0]       min_q, min_d;
   logic [5:0]       sec_q, sec_d;
   logic [6:0]       cs_q, cs_d;
   logic             fv_q, fv_d;
   logic             err_q, err_d;

   logic             an_chg, seg_chg;
   logic             an_blank, an_single, an_multi;
   logic [3:0]       low_cnt;
   logic             settle_done;
   logic             capture_go, mlow_err, cap_err;
   logic [4:0]       seg_dec;
   logic             seg_legal;
   logic [3:0]       seg_digit;
   logic             frame_done, range_bad, frame_ok, publish;
   logic [5:0]       f_min, f_sec;
   logic [6:0]       f_cs;

   assign an_chg      = (an != an_prev_q);
   assign seg_chg     = (seg != seg_prev_q);
   assign low_cnt     = 4'($countones(~an));
   assign an_blank    = (an == 8'hFF);
   assign an_single   = (low_cnt == 4'd1);
   assign an_multi    = (low_cnt >= 4'd2);
   assign settle_done = (cnt_q == CNT_LAST);

   assign seg_dec   = seg_decode(seg);
   assign seg_legal = seg_dec[4];
   assign seg_digit = seg_dec[3:0];

   // A full mask is seen the cycle after the completing capture; the frame is
   // evaluated from the registered digits in that cycle.
   assign frame_done = (mask_q == 6'h3F);
   assign range_bad  = (digit_q[5] > 4'd5) || (digit_q[3] > 4'd5);
   assign frame_ok   = frame_done && !range_bad;
   assign f_min      = join_bcd6(digit_q[5], digit_q[4]);
   assign f_sec      = join_bcd6(digit_q[3], digit_q[2]);
   assign f_cs       = join_bcd7(digit_q[1], digit_q[0]);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM: next state
   always_comb begin : fsm_next
      state_d = state_q;
      cnt_d   = cnt_q;
      if (an_blank || an_multi) begin
         // Blank or several digits enabled at once: nothing to capture.
         state_d = ST_IDLE;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SETTLE;
               cnt_d   = 8'd0;
            end
            ST_SETTLE: begin
               if (an_chg || seg_chg) begin
                  cnt_d = 8'd0;
               end else if (settle_done) begin
                  state_d = ST_HELD;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            ST_HELD: begin
               // Segment flicker while the same digit stays enabled is ignored.
               if (an_chg) begin
                  state_d = ST_SETTLE;
                  cnt_d   = 8'd0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 8'd0;
            end
         endcase
      end
   end

   // FSM: outputs
   always_comb begin : fsm_out
      capture_go = 1'b0;
      // Multi-low an reports once, when it first appears or changes.
      mlow_err   = an_multi && an_chg;
      if ((state_q == ST_SETTLE) && an_single && !an_chg && !seg_chg && settle_done) begin
         capture_go = 1'b1;
      end
   end

`ifdef SEG_DECODER_CONFIRM_EN
   logic        ref_vld_q, ref_vld_d;
   logic [18:0] ref_q, ref_d;
   logic [18:0] frame_key;

   assign frame_key = {f_min, f_sec, f_cs};

   always_comb begin : confirm_logic
      ref_vld_d = ref_vld_q;
      ref_d     = ref_q;
      publish   = frame_ok && ref_vld_q && (ref_q == frame_key);
      if (frame_ok) begin
         ref_vld_d = 1'b1;
         ref_d     = frame_key;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_vld_q <= 1'b0;
         ref_q     <= 19'd0;
      end else begin
         ref_vld_q <= ref_vld_d;
         ref_q     <= ref_d;
      end
   end
`else
   assign publish = frame_ok;
`endif

   // Capture, frame assembly and output update
   always_comb begin : datapath
      an_prev_d  = an;
      seg_prev_d = seg;
      digit_d    = digit_q;
      mask_d     = frame_done ? 6'h00 : mask_q;
      cap_err    = 1'b0;
      // Only slots 0..5 carry time digits; captures on an[7:6] do nothing.
      for (int i = 0; i < 6; i++) begin
         if (capture_go && !an[i]) begin
            if (seg_legal) begin
               digit_d[i] = seg_digit;
               mask_d[i]  = 1'b1;
            end else begin
               cap_err = 1'b1;
            end
         end
      end
      min_d = min_q;
      sec_d = sec_q;
      cs_d  = cs_q;
      if (publish) begin
         min_d = f_min;
         sec_d = f_sec;
         cs_d  = f_cs;
      end
      fv_d  = publish;
      err_d = mlow_err || cap_err || (frame_done && range_bad);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_prev_q  <= 8'hFF;
         seg_prev_q <= 7'h7F;
         mask_q     <= 6'h00;
         digit_q    <= '0;
         min_q      <= 6'd0;
         sec_q      <= 6'd0;
         cs_q       <= 7'd0;
         fv_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         an_prev_q  <= an_prev_d;
         seg_prev_q <= seg_prev_d;
         mask_q     <= mask_d;
         digit_q    <= digit_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         cs_q       <= cs_d;
         fv_q       <= fv_d;
         err_q      <= err_d;
      end
   end

   assign minutes      = min_q;
   assign seconds      = sec_q;
   assign centiseconds = cs_q;
   assign frame_valid  = fv_q;
   assign decode_err   = err_q;

endmodule

// File: doc/seven_segment_scan_decoder.md
SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16, meaning the number of consecutive stable clk cycles of an/seg required before a digit is captured (legal range 2..255).
REQ-002 The block SHALL have parameter CLK_HZ, default 100000000, meaning the clk frequency (documentation only; no logic depends on it).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seg  input  7  multiplexed segment bus, active-low, bit order {g,f,e,d,c,b,a}.
REQ-006 an  input  8  digit enables, active-low, an[0] = rightmost digit.
REQ-007 minutes  output  6  last accepted frame minutes, binary 0..59.
REQ-008 seconds  output  6  last accepted frame seconds, binary 0..59.
REQ-009 centiseconds  output  7  last accepted frame centiseconds, binary 0..99.
REQ-010 frame_valid  output  1  one-cycle pulse when minutes/seconds/centiseconds update.
REQ-011 decode_err  output  1  one-cycle pulse on illegal pattern, illegal an, or out-of-range frame.

Function
REQ-012 The block SHALL map digit slots: an[1:0] = centiseconds ones/tens, an[3:2] = seconds ones/tens, an[5:4] = minutes ones/tens; an[7:6] SHALL be ignored.
REQ-013 Legal patterns SHALL be 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10; any other seg value on slots 0..5 is illegal.
REQ-014 The block SHALL implement FSM states IDLE, SETTLE, HELD.
REQ-015 IDLE: an == 0xFF (blank); no capture; any single-low an SHALL enter SETTLE with counter cleared.
REQ-016 SETTLE: counter increments each cycle an and seg are unchanged from the previous cycle; any change SHALL clear the counter (new one-hot an restarts SETTLE, 0xFF returns to IDLE).
REQ-017 When the counter reaches SETTLE_CYCLES-1, the block SHALL capture the decoded digit into its slot, set that slot's bit in a 6-bit captured mask, and enter HELD.
REQ-018 HELD: no further capture; any change of an SHALL leave HELD (to SETTLE or IDLE); seg changes alone SHALL be ignored.
REQ-019 an with more than one low bit SHALL pulse decode_err once on entry, return to IDLE, and hold there until an changes.
REQ-020 An illegal pattern at capture time SHALL pulse decode_err, leave the slot and mask unchanged, and enter HELD.
REQ-021 Captures on an[7:6] SHALL neither set mask bits nor raise errors.
REQ-022 When the mask reaches 6'h3F, the block SHALL clear the mask and compute tens*10+ones per field in the next cycle; frame_valid or decode_err SHALL pulse one cycle after the completing capture.
REQ-023 Seconds tens > 5 or minutes tens > 5 SHALL pulse decode_err, leave the outputs unchanged, and suppress frame_valid.
REQ-024 A re-capture of an already-set slot before frame completion SHALL overwrite that slot's digit.
REQ-025 The output registers SHALL change only in the cycle that frame_valid is high.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE, counter 0, mask 0, slots 0, minutes/seconds/centiseconds 0, and frame_valid/decode_err 0.
REQ-027 Reset mid-frame SHALL discard partial captures; the first frame after release SHALL require all six slots anew.

Configuration
REQ-028 With macro SEG_DECODER_CONFIRM_EN defined, a completed in-range frame SHALL update the outputs and pulse frame_valid only if it equals the previous completed in-range frame; otherwise it SHALL only be stored as the comparison reference.
REQ-029 Without SEG_DECODER_CONFIRM_EN, every completed in-range frame SHALL update the outputs and pulse frame_valid.
REQ-030 With SEG_DECODER_CONFIRM_EN, reset SHALL clear the comparison reference to invalid.

Verification
REQ-031 Scan 12:34.56 (an[7:6] blank) with 20-cycle dwell per digit -> frame_valid once per scan; minutes=12, seconds=34, centiseconds=56.
REQ-032 Dwell of 10 cycles per digit with SETTLE_CYCLES=16 -> no capture, no frame_valid, outputs remain 0.
REQ-033 Slot an[2] shows seg=0x7F (blank) -> decode_err pulse, mask bit 2 stays clear, and no frame_valid until the next scan shows a legal pattern.
REQ-034 Scan 00:75.00 -> decode_err one cycle after the final capture; outputs unchanged.
REQ-035 an=0xFC held 20 cycles -> single decode_err pulse; FSM stays in IDLE until an changes.
REQ-036 rst asserted after 3 captured slots of 59:59.99, then a full scan -> outputs 59/59/99 only after all six slots are captured post-reset; with SEG_DECODER_CONFIRM_EN, after the second identical scan.
